geofence_driver: RTL and testbench
==================================

Name: geofence_driver

Overview:
- Upstream partner of the geofence engine.
- Accepts jobs from a host over a valid/ready load port. Each job is one object point followed by six fence points.
- Streams each job onto the engine's X/Y bus with the exact non-stalling cadence the engine expects.
- Waits for the engine's valid pulse, captures is_inside and returns a tagged result to the host.

Parameters:
- ID_W, 4, width of the job tag carried from load port to result port.
- TIMEOUT, 1023, maximum cycles allowed in WAIT before the error flag sets.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ld_valid  in  1  host point valid.
- ld_ready  out  1  driver can accept a point.
- ld_x  in  10  point X.
- ld_y  in  10  point Y.
- ld_id  in  ID_W  job tag; sampled on the first point of each job.
- X  out  10  X coordinate to the engine.
- Y  out  10  Y coordinate to the engine.
- gf_valid  in  1  engine result strobe.
- gf_inside  in  1  engine result; qualified by gf_valid.
- res_valid  out  1  one-cycle result pulse.
- res_inside  out  1  captured inside flag.
- res_id  out  ID_W  tag of the reported job.
- err_timeout  out  1  sticky; set when the engine never answers.

Behaviour:
- Job buffer:
  - Two banks (ping-pong), each 7 x 20 bits plus an ID and a full flag.
  - Host writes fill the bank selected by wr_bank. Point index wr_cnt runs 0..6; index 0 is the object, 1..6 are fence points.
  - ld_ready = 1 when the bank at wr_bank is not full.
  - When the 7th point is accepted: the bank goes full, wr_bank toggles, wr_cnt returns to 0.
- State machine, states SEND and WAIT:
  - Reset enters SEND with cnt = 0, because the engine samples the object in the first cycle after reset.
  - SEND:
    - X/Y = bank[rd_bank][cnt] if the frame is live, otherwise 0 (bubble frame).
    - cnt increments each cycle. At cnt = 6 go to WAIT.
  - WAIT:
    - X/Y = 0. The timeout counter increments.
    - When gf_valid = 1, go to SEND with cnt = 0 in the next cycle. The engine samples the next object in that cycle.
  - Live/bubble decision is made at each SEND entry (reset exit or gf_valid):
    - If the bank at rd_bank is full, the frame is live.
    - Otherwise the frame is a bubble: zero points, and the result is discarded.
  - When a live frame's result returns (gf_valid), the bank full flag clears and rd_bank toggles.
  - Load and release of the same bank in the same cycle cannot occur: the write side only targets a non-full bank.
- Result port:
  - On gf_valid with a live frame: res_valid = 1 on the next cycle, with res_inside = gf_inside and res_id = the bank ID.
  - Bubble frames never raise res_valid.
- Timeout:
  - The counter clears on SEND entry.
  - If it reaches TIMEOUT while in WAIT, err_timeout sets and stays set until reset. The FSM stays in WAIT.
  - A late gf_valid is still honoured.
- Reset values:
  - X = 0, Y = 0.
  - res_valid = 0, res_inside = 0, res_id = 0, err_timeout = 0.
  - ld_ready = 1 after reset (both banks empty).
  - Reset mid-job discards both banks.
- Arithmetic: all coordinates are unsigned 10-bit pass-through. The block does no geometry.

Optional Feature:
- Macro: GF_DRV_STATS_EN.
- With the macro defined, three 16-bit saturating counters are added, all cleared by reset:
  - jobs_done, incremented per live result;
  - inside_cnt, incremented per live result with res_inside = 1;
  - bubble_cnt, incremented per bubble frame issued.
- The counters are exposed as output ports.
- Without the macro, the counters and ports are absent and the remaining behaviour is identical.

Decomposition:
- Shared package gf_pkg:
  - coordinate width constant COORD_W = 10;
  - point typedef {x, y};
  - FENCE_PTS = 6 and FRAME_PTS = 7;
  - state enum {SEND, WAIT}.
- One natural sub-module, gf_job_buf: the ping-pong bank store with write and read pointers and full flags. The FSM and result logic stay in the top.

Test Plan:
- Idle after reset, no jobs loaded: one bubble frame with X = Y = 0 for 7 cycles. Model the engine with gf_valid 20 cycles later. Expect no res_valid, and a new bubble SEND starting the cycle after gf_valid.
- Load job id = 3: object (300,300), fence (100,100),(500,100),(600,300),(500,500),(100,500),(50,300).
  - After the current frame's gf_valid, X/Y must present those 7 points on consecutive cycles in load order.
  - gf_inside = 1 with gf_valid produces res_valid = 1, res_inside = 1, res_id = 3 one cycle later.
- Back-to-back: load jobs id = 1 and id = 2 while the first is streaming.
  - ld_ready drops after the second job (both banks full).
  - Job 2 object appears the cycle after job 1's gf_valid; ld_ready rises once job 1's result returns.
- Hold gf_valid low in WAIT: err_timeout rises at exactly TIMEOUT cycles. A later gf_valid still yields res_valid, and err_timeout stays 1.
- Assert reset mid-SEND at cnt = 3 with one bank full: afterwards ld_ready = 1, X/Y restart a bubble frame from cnt = 0, and no stale result is reported.
- With GF_DRV_STATS_EN, after 5 live jobs (2 inside) and 1 bubble: jobs_done = 5, inside_cnt = 2, bubble_cnt = 1.

Source files
------------

// File: rtl/gf_pkg.sv
// -----------------------------------------------------------------------------
// gf_pkg
// Shared types and constants for the geofence driver and its job buffer.
//   COORD_W   : coordinate width (unsigned pass-through)
//   FENCE_PTS : fence vertices per job
//   FRAME_PTS : points per job frame (object + fence)
//   IDX_W     : width of a point index within a frame
//   point_t   : one {x, y} coordinate pair
//   state_t   : driver FSM states
// -----------------------------------------------------------------------------
package gf_pkg;

    localparam int COORD_W   = 10;
    localparam int FENCE_PTS = 6;
    localparam int FRAME_PTS = FENCE_PTS + 1;
    localparam int IDX_W     = $clog2(FRAME_PTS);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic {
        SEND = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Saturating increment for the 16-bit statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/geofence_driver_if.sv
// -----------------------------------------------------------------------------
// geofence_driver_if
// Bundles the host load port, the engine X/Y bus, the engine result strobe and
// the host result port of the geofence driver.
//   Load port   : ld_valid, ld_ready, ld_x, ld_y, ld_id
//   Engine bus  : X, Y (to engine), gf_valid, gf_inside (from engine)
//   Result port : res_valid, res_inside, res_id, err_timeout
// Modports:
//   master : the driver itself
//   slave  : the host/engine side (testbench or surrounding system)
// -----------------------------------------------------------------------------
interface geofence_driver_if #(
    parameter int ID_W = 4
);
    logic                       ld_valid;
    logic                       ld_ready;
    logic [gf_pkg::COORD_W-1:0] ld_x;
    logic [gf_pkg::COORD_W-1:0] ld_y;
    logic [ID_W-1:0]            ld_id;

    logic [gf_pkg::COORD_W-1:0] X;
    logic [gf_pkg::COORD_W-1:0] Y;
    logic                       gf_valid;
    logic                       gf_inside;

    logic                       res_valid;
    logic                       res_inside;
    logic [ID_W-1:0]            res_id;
    logic                       err_timeout;

    modport master (
        input  ld_valid, ld_x, ld_y, ld_id, gf_valid, gf_inside,
        output ld_ready, X, Y, res_valid, res_inside, res_id, err_timeout
    );

    modport slave (
        output ld_valid, ld_x, ld_y, ld_id, gf_valid, gf_inside,
        input  ld_ready, X, Y, res_valid, res_inside, res_id, err_timeout
    );

endinterface

// File: rtl/gf_job_buf.sv
// -----------------------------------------------------------------------------
// gf_job_buf
// Ping-pong job store: two banks of FRAME_PTS points plus a job tag and a full
// flag each. The write side fills the bank at wr_bank point by point; the read
// side presents the point at rd_idx of the bank at rd_bank.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (clears pointers/flags)
//   wr_en       : accept wr_pt (and wr_id on the first point of a job)
//   wr_ready    : bank at wr_bank is not full
//   rd_idx      : point index presented on rd_pt
//   rd_release  : current read bank is done; clear its full flag and swap
//   rd_pt/rd_id : point and tag of the read bank
//   nxt_full    : full flag of the bank that is the read bank after this cycle
// -----------------------------------------------------------------------------
module gf_job_buf
    import gf_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  point_t           wr_pt,
    input  logic [ID_W-1:0]  wr_id,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             rd_release,
    output point_t           rd_pt,
    output logic [ID_W-1:0]  rd_id,
    output logic             nxt_full
);

    point_t          mem    [0:1][0:FRAME_PTS-1];
    logic [ID_W-1:0] id_mem [0:1];

    logic [1:0]       full_reg, full_next;
    logic             wr_bank_reg;
    logic             rd_bank_reg;
    logic [IDX_W-1:0] wr_cnt_reg;
    logic             wr_done;

    assign wr_done  = wr_en && (wr_cnt_reg == IDX_W'(FRAME_PTS - 1));
    assign wr_ready = ~full_reg[wr_bank_reg];

    // Storage needs no reset: the full flags alone decide whether it is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank_reg][wr_cnt_reg] <= wr_pt;
            if (wr_cnt_reg == '0) begin
                id_mem[wr_bank_reg] <= wr_id;
            end
        end
    end

    // The write side only ever targets a non-full bank, so set and clear never
    // hit the same bank in one cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] =
                (full_reg[gi] | (wr_done && (wr_bank_reg == 1'(gi))))
                & ~(rd_release && (rd_bank_reg == 1'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_reg    <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
        end else begin
            full_reg <= full_next;
            if (wr_en) begin
                wr_cnt_reg <= wr_done ? '0 : wr_cnt_reg + 1'b1;
            end
            if (wr_done) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
            if (rd_release) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
        end
    end

    assign rd_pt    = mem[rd_bank_reg][rd_idx];
    assign rd_id    = id_mem[rd_bank_reg];
    assign nxt_full = rd_release ? full_reg[~rd_bank_reg] : full_reg[rd_bank_reg];

endmodule

// File: rtl/geofence_driver.sv
// -----------------------------------------------------------------------------
// geofence_driver
// Accepts jobs (one object point + six fence points) from a host, streams each
// job onto the geofence engine X/Y bus in a fixed 7-cycle frame, waits for the
// engine's result strobe and returns a tagged inside/outside result.
// When no job is ready at the start of a frame a bubble frame (all zero
// points) is sent and its result is dropped, keeping the engine cadence fixed.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : geofence_driver_if.master (load port, engine bus, results)
//   jobs_done, inside_cnt, bubble_cnt : 16-bit saturating statistics, present
//                only when GF_DRV_STATS_EN is defined
// Parameters:
//   ID_W    : job tag width
//   TIMEOUT : cycles in WAIT before err_timeout sets (sticky)
// Optional feature macro: GF_DRV_STATS_EN
// -----------------------------------------------------------------------------
module geofence_driver
    import gf_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    geofence_driver_if.master   bus
`ifdef GF_DRV_STATS_EN
    ,
    output logic [15:0]         jobs_done,
    output logic [15:0]         inside_cnt,
    output logic [15:0]         bubble_cnt
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic             live_reg, live_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic             err_reg, err_next;

    logic             res_valid_reg;
    logic             res_inside_reg;
    logic [ID_W-1:0]  res_id_reg;

    logic             wr_en;
    logic             wr_ready;
    point_t           wr_pt;
    point_t           rd_pt;
    logic [ID_W-1:0]  rd_id;
    logic             nxt_full;
    logic             release_job;

    assign wr_pt = '{x: bus.ld_x, y: bus.ld_y};
    assign wr_en = bus.ld_valid && wr_ready;

    // A live frame's result frees its bank; a bubble's result is ignored.
    assign release_job = (state_reg == WAIT) && bus.gf_valid && live_reg;

    gf_job_buf #(
        .ID_W (ID_W)
    ) u_job_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_pt      (wr_pt),
        .wr_id      (bus.ld_id),
        .wr_ready   (wr_ready),
        .rd_idx     (cnt_reg),
        .rd_release (release_job),
        .rd_pt      (rd_pt),
        .rd_id      (rd_id),
        .nxt_full   (nxt_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SEND;
            cnt_reg   <= '0;
            live_reg  <= 1'b0;
            tmo_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            live_reg  <= live_next;
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        live_next  = live_reg;
        tmo_next   = tmo_reg;
        err_next   = err_reg;
        bus.X      = '0;
        bus.Y      = '0;

        case (state_reg)
            SEND: begin
                tmo_next = '0;
                if (live_reg) begin
                    bus.X = rd_pt.x;
                    bus.Y = rd_pt.y;
                end
                if (cnt_reg == IDX_W'(FRAME_PTS - 1)) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT: begin
                // Counter saturates, so err sets exactly once when the
                // TIMEOUT-th WAIT cycle completes.
                if (tmo_reg != TMO_W'(TIMEOUT)) begin
                    tmo_next = tmo_reg + 1'b1;
                end
                if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                    err_next = 1'b1;
                end
                if (bus.gf_valid) begin
                    state_next = SEND;
                    cnt_next   = '0;
                    tmo_next   = '0;
                    // Live/bubble is decided on the bank that will be read
                    // next, after any release happening this cycle.
                    live_next  = nxt_full;
                end
            end
            default: begin
                state_next = SEND;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_reg  <= 1'b0;
            res_inside_reg <= 1'b0;
            res_id_reg     <= '0;
        end else begin
            res_valid_reg <= release_job;
            if (release_job) begin
                res_inside_reg <= bus.gf_inside;
                res_id_reg     <= rd_id;
            end
        end
    end

    assign bus.ld_ready    = wr_ready;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_inside  = res_inside_reg;
    assign bus.res_id      = res_id_reg;
    assign bus.err_timeout = err_reg;

`ifdef GF_DRV_STATS_EN
    logic [15:0] jobs_done_reg;
    logic [15:0] inside_cnt_reg;
    logic [15:0] bubble_cnt_reg;
    logic        bubble_issued;

    // A bubble frame counts once, in its first SEND cycle (covers reset exit).
    assign bubble_issued = (state_reg == SEND) && (cnt_reg == '0) && !live_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jobs_done_reg  <= '0;
            inside_cnt_reg <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (release_job) begin
                jobs_done_reg <= sat_inc16(jobs_done_reg);
            end
            if (release_job && bus.gf_inside) begin
                inside_cnt_reg <= sat_inc16(inside_cnt_reg);
            end
            if (bubble_issued) begin
                bubble_cnt_reg <= sat_inc16(bubble_cnt_reg);
            end
        end
    end

    assign jobs_done  = jobs_done_reg;
    assign inside_cnt = inside_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_geofence_driver.sv
// -----------------------------------------------------------------------------
// tb_geofence_driver
// Directed testbench for geofence_driver. Outputs are sampled on the falling
// edge; inputs for the next rising edge are driven right after sampling.
// Optional: define GF_DRV_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_geofence_driver;

    localparam int ID_W    = 4;
    localparam int TIMEOUT = 1023;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] jx [0:9][0:6];
    logic [9:0] jy [0:9][0:6];

    geofence_driver_if #(.ID_W(ID_W)) bus ();

`ifdef GF_DRV_STATS_EN
    logic [15:0] jobs_done;
    logic [15:0] inside_cnt;
    logic [15:0] bubble_cnt;
`endif

    geofence_driver #(
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef GF_DRV_STATS_EN
        ,
        .jobs_done  (jobs_done),
        .inside_cnt (inside_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one load-port point (or idle when v = 0).
    task automatic drive_ld(input logic v, input int id, input int idx);
        bus.ld_valid = v;
        if (v) begin
            bus.ld_x  = jx[id][idx];
            bus.ld_y  = jy[id][idx];
            bus.ld_id = 4'(id);
        end else begin
            bus.ld_x  = '0;
            bus.ld_y  = '0;
            bus.ld_id = '0;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.gf_valid  = 1'b0;
        bus.gf_inside = 1'b0;
        drive_ld(1'b0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({bus.X, bus.Y} !== 20'd0) begin
            n_fail++; $display("FAIL reset_xy got %h exp 0", {bus.X, bus.Y});
        end
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_res_valid got %b exp 0", bus.res_valid);
        end
        n_checks++;
        if (bus.res_inside !== 1'b0) begin
            n_fail++; $display("FAIL reset_res_inside got %b exp 0", bus.res_inside);
        end
        n_checks++;
        if (bus.res_id !== 4'd0) begin
            n_fail++; $display("FAIL reset_res_id got %0d exp 0", bus.res_id);
        end
        n_checks++;
        if (bus.err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b exp 0", bus.err_timeout);
        end
        n_checks++;
        if (bus.ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ld_ready got %b exp 1", bus.ld_ready);
        end
        $display("test_reset done");
    endtask

    // Bubble frame after reset; engine answers 20 cycles after frame start.
    task automatic test_idle_bubble();
        for (int c = 0; c <= 20; c++) begin
            n_checks++;
            if ({bus.X, bus.Y} !== 20'd0 || bus.res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle c=%0d xy=%h res_valid=%b exp xy=0 res_valid=0",
                         c, {bus.X, bus.Y}, bus.res_valid);
            end
            bus.gf_valid  = (c == 20);
            bus.gf_inside = 1'b1;
            @(negedge clk);
        end
        bus.gf_valid = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_discard res_valid got %b exp 0", bus.res_valid);
        end
        $display("test_idle_bubble done");
    endtask

    // Load job 3 during a bubble frame; it streams in the following frame.
    task automatic test_load();
        logic [19:0] exp_xy;
        for (int c = 0; c <= 21; c++) begin
            drive_ld(c < 7, 3, (c < 7) ? c : 0);
            if (c < 7) begin
                n_checks++;
                if (bus.ld_ready !== 1'b1) begin
                    n_fail++; $display("FAIL load_ready c=%0d got %b exp 1", c, bus.ld_ready);
                end
            end
            if (c >= 12 && c <= 18) exp_xy = {jx[3][c-12], jy[3][c-12]};
            else                    exp_xy = 20'd0;
            n_checks++;
            if ({bus.X, bus.Y} !== exp_xy) begin
                n_fail++; $display("FAIL load_xy c=%0d got %h exp %h", c, {bus.X, bus.Y}, exp_xy);
            end
            if (c == 12) begin
                n_checks++;
                if (bus.res_valid !== 1'b0) begin
                    n_fail++; $display("FAIL load_bubble_res got %b exp 0", bus.res_valid);
                end
            end
            bus.gf_valid  = (c == 11 || c == 21);
            bus.gf_inside = (c == 21);
            @(negedge clk);
        end
        bus.gf_valid = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_inside !== 1'b1 || bus.res_id !== 4'd3) begin
            n_fail++;
            $display("FAIL load_result got v=%b in=%b id=%0d exp v=1 in=1 id=3",
                     bus.res_valid, bus.res_inside, bus.res_id);
        end
        n_checks++;
        if ({bus.X, bus.Y} !== 20'd0) begin
            n_fail++; $display("FAIL load_next_bubble got %h exp 0", {bus.X, bus.Y});
        end
        $display("test_load done");
    endtask

    // Job 1 loaded in a bubble frame, job 2 loaded while job 1 streams.
    task automatic test_back_to_back();
        logic [19:0] exp_xy;
        for (int c = 0; c <= 24; c++) begin
            if (c < 7)       drive_ld(1'b1, 1, c);
            else if (c < 14) drive_ld(1'b1, 2, c - 7);
            else             drive_ld(1'b0, 0, 0);
            if (c < 14) begin
                n_checks++;
                if (bus.ld_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_ready c=%0d got %b exp 1", c, bus.ld_ready);
                end
            end
            if (c == 14 || c == 17) begin
                n_checks++;
                if (bus.ld_ready !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_full c=%0d ld_ready got %b exp 0", c, bus.ld_ready);
                end
            end
            if (c >= 8 && c <= 14)       exp_xy = {jx[1][c-8], jy[1][c-8]};
            else if (c >= 18 && c <= 24) exp_xy = {jx[2][c-18], jy[2][c-18]};
            else                         exp_xy = 20'd0;
            n_checks++;
            if ({bus.X, bus.Y} !== exp_xy) begin
                n_fail++; $display("FAIL b2b_xy c=%0d got %h exp %h", c, {bus.X, bus.Y}, exp_xy);
            end
            if (c == 1 || c == 8 || c == 19) begin
                n_checks++;
                if (bus.res_valid !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_res_idle c=%0d got %b exp 0", c, bus.res_valid);
                end
            end
            if (c == 18) begin
                n_checks++;
                if (bus.res_valid !== 1'b1 || bus.res_inside !== 1'b0 || bus.res_id !== 4'd1) begin
                    n_fail++;
                    $display("FAIL b2b_result got v=%b in=%b id=%0d exp v=1 in=0 id=1",
                             bus.res_valid, bus.res_inside, bus.res_id);
                end
                n_checks++;
                if (bus.ld_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_ready_back got %b exp 1", bus.ld_ready);
                end
            end
            bus.gf_valid  = (c == 7 || c == 17);
            bus.gf_inside = 1'b0;
            @(negedge clk);
        end
        $display("test_back_to_back done");
    endtask

    // Engine silent in WAIT of job 2's frame; answer arrives late.
    task automatic test_timeout();
        for (int k = 0; k <= TIMEOUT + 5; k++) begin
            if (k == 0 || k == TIMEOUT - 1) begin
                n_checks++;
                if (bus.err_timeout !== 1'b0) begin
                    n_fail++; $display("FAIL tmo_early k=%0d got %b exp 0", k, bus.err_timeout);
                end
            end
            if (k == TIMEOUT) begin
                n_checks++;
                if (bus.err_timeout !== 1'b1) begin
                    n_fail++; $display("FAIL tmo_set k=%0d got %b exp 1", k, bus.err_timeout);
                end
                n_checks++;
                if ({bus.X, bus.Y} !== 20'd0 || bus.res_valid !== 1'b0) begin
                    n_fail++; $display("FAIL tmo_wait_idle xy=%h v=%b exp 0", {bus.X, bus.Y}, bus.res_valid);
                end
            end
            bus.gf_valid  = (k == TIMEOUT + 5);
            bus.gf_inside = 1'b1;
            @(negedge clk);
        end
        bus.gf_valid = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_inside !== 1'b1 || bus.res_id !== 4'd2) begin
            n_fail++;
            $display("FAIL tmo_late_result got v=%b in=%b id=%0d exp v=1 in=1 id=2",
                     bus.res_valid, bus.res_inside, bus.res_id);
        end
        n_checks++;
        if (bus.err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL tmo_sticky got %b exp 1", bus.err_timeout);
        end
        $display("test_timeout done");
    endtask

    // Reset lands at cnt = 3 of live job 5; job 6 then verifies the restart.
    task automatic test_reset_mid_send();
        logic [19:0] exp_xy;
        for (int c = 0; c <= 11; c++) begin
            drive_ld(c < 7, 5, (c < 7) ? c : 0);
            if (c >= 8) begin
                exp_xy = {jx[5][c-8], jy[5][c-8]};
                n_checks++;
                if ({bus.X, bus.Y} !== exp_xy) begin
                    n_fail++; $display("FAIL mid_xy c=%0d got %h exp %h", c, {bus.X, bus.Y}, exp_xy);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (bus.res_valid !== 1'b0) begin
                    n_fail++; $display("FAIL mid_bubble_res got %b exp 0", bus.res_valid);
                end
            end
            bus.gf_valid  = (c == 7);
            bus.gf_inside = 1'b0;
            if (c != 11) @(negedge clk);
        end
        reset        = 1'b1;
        bus.gf_valid = 1'b0;
        drive_ld(1'b0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus.ld_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after_reset rdy=%b v=%b err=%b exp rdy=1 v=0 err=0",
                     bus.ld_ready, bus.res_valid, bus.err_timeout);
        end
        for (int r = 0; r <= 19; r++) begin
            drive_ld(r < 7, 6, (r < 7) ? r : 0);
            if (r >= 11 && r <= 17) exp_xy = {jx[6][r-11], jy[6][r-11]};
            else                    exp_xy = 20'd0;
            n_checks++;
            if ({bus.X, bus.Y} !== exp_xy) begin
                n_fail++; $display("FAIL mid_restart_xy r=%0d got %h exp %h", r, {bus.X, bus.Y}, exp_xy);
            end
            if (r == 11) begin
                n_checks++;
                if (bus.res_valid !== 1'b0) begin
                    n_fail++; $display("FAIL mid_stale_res got %b exp 0", bus.res_valid);
                end
            end
            bus.gf_valid  = (r == 10 || r == 19);
            bus.gf_inside = (r == 10);
            @(negedge clk);
        end
        bus.gf_valid = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_inside !== 1'b0 || bus.res_id !== 4'd6) begin
            n_fail++;
            $display("FAIL mid_job6_result got v=%b in=%b id=%0d exp v=1 in=0 id=6",
                     bus.res_valid, bus.res_inside, bus.res_id);
        end
        $display("test_reset_mid_send done");
    endtask

`ifdef GF_DRV_STATS_EN
    // One bubble after reset, then five live jobs (2nd and 4th inside); a
    // sixth job keeps the frame after the last result live.
    task automatic test_stats();
        reset        = 1'b1;
        bus.gf_valid = 1'b0;
        drive_ld(1'b0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (jobs_done !== 16'd0 || inside_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_reset got %0d/%0d/%0d exp 0/0/0", jobs_done, inside_cnt, bubble_cnt);
        end
        for (int r = 0; r <= 48; r++) begin
            drive_ld((r % 8 < 7) && (r < 48), 4 + r / 8, r % 8);
            bus.gf_valid  = (r % 8 == 7);
            bus.gf_inside = (r / 8 == 2) || (r / 8 == 4);
            @(negedge clk);
        end
        n_checks++;
        if (jobs_done !== 16'd5) begin
            n_fail++; $display("FAIL stats_jobs got %0d exp 5", jobs_done);
        end
        n_checks++;
        if (inside_cnt !== 16'd2) begin
            n_fail++; $display("FAIL stats_inside got %0d exp 2", inside_cnt);
        end
        n_checks++;
        if (bubble_cnt !== 16'd1) begin
            n_fail++; $display("FAIL stats_bubble got %0d exp 1", bubble_cnt);
        end
        $display("test_stats done");
    endtask
`endif

    initial begin
        for (int id = 0; id < 10; id++) begin
            for (int i = 0; i < 7; i++) begin
                jx[id][i] = 10'(id * 100 + i * 11);
                jy[id][i] = 10'(1000 - id * 90 - i * 13);
            end
        end
        jx[3][0] = 10'd300; jy[3][0] = 10'd300;
        jx[3][1] = 10'd100; jy[3][1] = 10'd100;
        jx[3][2] = 10'd500; jy[3][2] = 10'd100;
        jx[3][3] = 10'd600; jy[3][3] = 10'd300;
        jx[3][4] = 10'd500; jy[3][4] = 10'd500;
        jx[3][5] = 10'd100; jy[3][5] = 10'd500;
        jx[3][6] = 10'd50;  jy[3][6] = 10'd300;

        test_reset();
        test_idle_bubble();
        test_load();
        test_back_to_back();
        test_timeout();
        test_reset_mid_send();
`ifdef GF_DRV_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
